// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and an async-read ROM (slave).
interface fetch_stage_if;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_addr_o,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_addr_o,
    output imem_rdata_i
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, imem address and IF/ID pipeline register.
// Priority per edge: redirect > stall > flush > normal fetch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 redirect_i,
  input  logic [31:0]          redirect_pc_i,
  fetch_stage_if.master        imem,
  output logic [31:0]          if_id_instr_o,
  output logic [31:0]          if_id_pc4_o,
  output logic [15:0]          if_id_imm_o,
  output logic                 if_id_valid_o,
  output logic                 misalign_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] pc4;

  assign pc4 = pc_q + 32'd4;

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    misalign_d = redirect_i & (redirect_pc_i[1:0] != 2'b00);

    if (redirect_i) begin
      // Target is force-aligned; misalign_o reports the dropped low bits.
      pc_d    = {redirect_pc_i[31:2], 2'b00};
      instr_d = NOP_WORD;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (stall_i) begin
      pc_d    = pc_q;
    end else if (flush_i) begin
      pc_d    = pc4;
      instr_d = NOP_WORD;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc4;
      instr_d = imem.imem_rdata_i;
      pc4_d   = pc4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_WORD;
      pc4_q      <= 32'd0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem.imem_addr_o = pc_q;
  assign if_id_instr_o    = instr_q;
  assign if_id_pc4_o      = pc4_q;
  assign if_id_imm_o      = instr_q[15:0];
  assign if_id_valid_o    = valid_q;
  assign misalign_o       = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected post-edge state, monitor checks it.
module tb_fetch_stage;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        mis;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc4_o;
  logic [15:0] if_id_imm_o;
  logic        if_id_valid_o;
  logic        misalign_o;

  int total;
  int bad;
  exp_t exp_q[$];

  fetch_stage_if imem_bus ();

  // ROM: word[i] = 0x2000_0000 + i, asynchronous read
  assign imem_bus.imem_rdata_i = 32'h2000_0000 + (imem_bus.imem_addr_o >> 2);

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (imem_bus),
    .if_id_instr_o (if_id_instr_o),
    .if_id_pc4_o   (if_id_pc4_o),
    .if_id_imm_o   (if_id_imm_o),
    .if_id_valid_o (if_id_valid_o),
    .misalign_o    (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic chk_state(input string tag, input exp_t e);
    chk({tag, " addr"},  imem_bus.imem_addr_o, e.addr);
    chk({tag, " instr"}, if_id_instr_o, e.instr);
    chk({tag, " pc4"},   if_id_pc4_o, e.pc4);
    chk({tag, " imm"},   {16'h0, if_id_imm_o}, {16'h0, e.instr[15:0]});
    chk({tag, " valid"}, {31'h0, if_id_valid_o}, {31'h0, e.valid});
    chk({tag, " mis"},   {31'h0, misalign_o}, {31'h0, e.mis});
  endtask

  // Monitor: each active edge that had stimulus queued is checked just after the edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk_state("edge", e);
    end
  end

  // Drive inputs for the next edge and queue the state expected after it.
  task automatic step(input logic st, input logic fl, input logic rd, input logic [31:0] rpc,
                      input logic [31:0] a, input logic [31:0] ins, input logic [31:0] p4,
                      input logic v, input logic m);
    exp_t e;
    stall_i       = st;
    flush_i       = fl;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    e.addr = a; e.instr = ins; e.pc4 = p4; e.valid = v; e.mis = m;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  exp_t rst_e;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    rst_e.addr = 32'h0; rst_e.instr = 32'h0; rst_e.pc4 = 32'h0; rst_e.valid = 1'b0;
    rst_e.mis = 1'b0;

    repeat (3) @(negedge clk);
    chk_state("reset", rst_e);
    rst_n = 1'b1;

    // Sequential fetch
    step(0, 0, 0, 0, 32'h0000_0004, 32'h2000_0000, 32'h0000_0004, 1, 0);
    step(0, 0, 0, 0, 32'h0000_0008, 32'h2000_0001, 32'h0000_0008, 1, 0);
    // Stall two cycles at pc=0x8
    step(1, 0, 0, 0, 32'h0000_0008, 32'h2000_0001, 32'h0000_0008, 1, 0);
    step(1, 0, 0, 0, 32'h0000_0008, 32'h2000_0001, 32'h0000_0008, 1, 0);
    step(0, 0, 0, 0, 32'h0000_000C, 32'h2000_0002, 32'h0000_000C, 1, 0);
    step(0, 0, 0, 0, 32'h0000_0010, 32'h2000_0003, 32'h0000_0010, 1, 0);
    // Flush at pc=0x10, then word at 0x14 captured
    step(0, 1, 0, 0, 32'h0000_0014, 32'h0000_0000, 32'h0000_0000, 0, 0);
    step(0, 0, 0, 0, 32'h0000_0018, 32'h2000_0005, 32'h0000_0018, 1, 0);
    // Redirect beats stall
    step(1, 0, 1, 32'h0000_0040, 32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 0, 0);
    step(0, 0, 0, 0, 32'h0000_0044, 32'h2000_0010, 32'h0000_0044, 1, 0);
    // Stall beats flush
    step(1, 1, 0, 0, 32'h0000_0044, 32'h2000_0010, 32'h0000_0044, 1, 0);
    // Misaligned redirect: one-cycle pulse
    step(0, 0, 1, 32'h0000_0103, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 0, 1);
    step(0, 0, 0, 0, 32'h0000_0104, 32'h2000_0040, 32'h0000_0104, 1, 0);
    // Back-to-back misaligned redirects, redirect also beats flush
    step(0, 1, 1, 32'h0000_0103, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 0, 1);
    step(0, 0, 1, 32'h0000_0202, 32'h0000_0200, 32'h0000_0000, 32'h0000_0000, 0, 1);
    // Wrap-around
    step(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 0, 0);
    step(0, 0, 0, 0, 32'h0000_0000, 32'h5FFF_FFFF, 32'h0000_0000, 1, 0);
    // Run up to pc=0x24
    for (int i = 1; i <= 9; i++) begin
      step(0, 0, 0, 0, 32'(4 * i), 32'h2000_0000 + 32'(i - 1), 32'(4 * i), 1, 0);
    end
    chk("pre-reset addr", imem_bus.imem_addr_o, 32'h0000_0024);
    chk("pre-reset valid", {31'h0, if_id_valid_o}, 32'h1);

    // Async reset between edges, with stall and redirect pending
    #2;
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0080;
    rst_n = 1'b0;
    #1;
    chk_state("async-reset", rst_e);
    repeat (2) @(negedge clk);
    chk_state("reset-held", rst_e);
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    rst_n = 1'b1;
    step(0, 0, 0, 0, 32'h0000_0004, 32'h2000_0000, 32'h0000_0004, 1, 0);
    step(0, 0, 0, 0, 32'h0000_0008, 32'h2000_0001, 32'h0000_0008, 1, 0);

    @(posedge clk);
    #2;
    chk("queue drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound
  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
